debug_mem_dumper: RTL



---
 rtl/debug_mem_dumper.sv | 118 +++++++++++
 1 files changed

// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper
//   Sweeps every reachable word of the data memory through its debug read
//   port and streams each word, least-significant byte first, to the debug
//   UART transmitter. Words go out in ascending address order.
//
// Ports
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_start          dump request, only honoured while idle
//   i_debug_mem      word returned by the memory debug port for o_debug_addr
//   i_tx_done        UART TX done tick, only honoured while waiting on a byte
//   o_debug_addr     word-aligned byte address presented to the debug port
//   o_tx_data        byte currently offered to the UART
//   o_tx_start       one-cycle request to transmit o_tx_data
//   o_busy           high while a dump is in progress
//   o_done           one-cycle pulse once the final byte has been accepted
module debug_mem_dumper #(
  parameter int unsigned B = 32,
  parameter int unsigned W = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [B-1:0] i_debug_mem,
  input  logic         i_tx_done,
  output logic [W-1:0] o_debug_addr,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_start,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned NBYTES = B / 8;
  localparam int unsigned BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned WIW    = W - 2;

  localparam logic [BIW-1:0] BI_LAST = BIW'(NBYTES - 1);
  localparam logic [WIW-1:0] WI_LAST = '1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [WIW-1:0] wi_q, wi_d;
  logic [BIW-1:0] bi_q, bi_d;
  logic [B-1:0]   word_buf_q, word_buf_d;

  always_comb begin
    state_d    = state_q;
    wi_d       = wi_q;
    bi_d       = bi_q;
    word_buf_d = word_buf_q;
    case (state_q)
      S_IDLE: begin
        wi_d = '0;
        bi_d = '0;
        if (i_start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Debug port is combinational on o_debug_addr, which is already
        // stable for this word, so the data can be captured here.
        word_buf_d = i_debug_mem;
        bi_d       = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (bi_q != BI_LAST) begin
            bi_d    = bi_q + 1'b1;
            state_d = S_SEND;
          end else begin
            // Word index wraps to zero after the final word, leaving the
            // address at 0 for the next dump.
            bi_d    = '0;
            wi_d    = wi_q + 1'b1;
            state_d = (wi_q != WI_LAST) ? S_LOAD : S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      wi_q       <= '0;
      bi_q       <= '0;
      word_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      wi_q       <= wi_d;
      bi_q       <= bi_d;
      word_buf_q <= word_buf_d;
    end
  end

  // Every output is a decode of registered state only.
  assign o_debug_addr = {wi_q, 2'b00};
  assign o_tx_data    = word_buf_q[{bi_q, 3'b000} +: 8];
  assign o_tx_start   = (state_q == S_SEND);
  assign o_busy       = (state_q == S_LOAD) || (state_q == S_SEND) ||
                        (state_q == S_WAIT);
  assign o_done       = (state_q == S_DONE);

endmodule
